sram_arb2: RTL and testbench

//   Two-port arbiter/sequencer in front of one single-port sim_ram (1-cycle read latency).
//   m0 = instruction-fetch side, m1 = load/store side; both share the RAM.

---
 rtl/sram_arb2.sv | 103 ++++++++++
 tb/tb_sram_arb2.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb2.sv
// Two-port arbiter in front of a single-port 1-cycle-latency RAM.
// One response outstanding at most; the read address is held so ram_dout stays stable while a response stalls.
module sram_arb2 #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_cmd_valid,
    output logic            m0_cmd_ready,
    input  logic            m0_cmd_read,
    input  logic [AW-1:0]   m0_cmd_addr,
    input  logic [DW-1:0]   m0_cmd_wdata,
    input  logic [DW/8-1:0] m0_cmd_wmask,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_rdata,
    input  logic            m1_cmd_valid,
    output logic            m1_cmd_ready,
    input  logic            m1_cmd_read,
    input  logic [AW-1:0]   m1_cmd_addr,
    input  logic [DW-1:0]   m1_cmd_wdata,
    input  logic [DW/8-1:0] m1_cmd_wmask,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_we,
    output logic [DW/8-1:0] ram_wem,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);
    localparam int unsigned MW = DW / 8;
    localparam bit RR = (ARB_MODE != 0);

    logic          rsp_pend;
    logic          rsp_owner;
    logic          rsp_is_read;
    logic          rr_last;
    logic [AW-1:0] hold_addr;

    logic          rsp_done;
    logic          can_issue;
    logic          sel;
    logic          accept;
    logic          sel_read;
    logic [AW-1:0] sel_addr;
    logic [AW-1:0] sel_word;
    logic [DW-1:0] sel_wdata;
    logic [MW-1:0] sel_wmask;
    logic [3:0]    unused_addr_lsb;

    assign unused_addr_lsb = {m0_cmd_addr[1:0], m1_cmd_addr[1:0]};

    // Response channel: only the owner sees valid/data; everything is quiet during reset.
    assign m0_rsp_valid = ~rst & rsp_pend & ~rsp_owner;
    assign m1_rsp_valid = ~rst & rsp_pend & rsp_owner;
    assign m0_rsp_rdata = (m0_rsp_valid & rsp_is_read) ? ram_dout : '0;
    assign m1_rsp_rdata = (m1_rsp_valid & rsp_is_read) ? ram_dout : '0;

    assign rsp_done  = rsp_owner ? (m1_rsp_valid & m1_rsp_ready)
                                 : (m0_rsp_valid & m0_rsp_ready);
    assign can_issue = ~rst & (~rsp_pend | rsp_done);

    // sel=1 picks m1: m1 alone, or a contest won by round-robin when m0 went last.
    assign sel    = m1_cmd_valid & (~m0_cmd_valid | (RR & ~rr_last));
    assign accept = can_issue & (m0_cmd_valid | m1_cmd_valid);

    assign m0_cmd_ready = accept & ~sel;
    assign m1_cmd_ready = accept & sel;

    assign sel_read  = sel ? m1_cmd_read  : m0_cmd_read;
    assign sel_addr  = sel ? m1_cmd_addr  : m0_cmd_addr;
    assign sel_wdata = sel ? m1_cmd_wdata : m0_cmd_wdata;
    assign sel_wmask = sel ? m1_cmd_wmask : m0_cmd_wmask;
    assign sel_word  = {2'b00, sel_addr[AW-1:2]};

    assign ram_addr = accept ? sel_word : hold_addr;
    assign ram_we   = accept & ~sel_read;
    assign ram_wem  = (accept & ~sel_read) ? sel_wmask : '0;
    assign ram_din  = sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend    <= 1'b0;
            rsp_owner   <= 1'b0;
            rsp_is_read <= 1'b0;
            hold_addr   <= '0;
            rr_last     <= 1'b1;
        end else if (accept) begin
            rsp_pend    <= 1'b1;
            rsp_owner   <= sel;
            rsp_is_read <= sel_read;
            rr_last     <= sel;
            if (sel_read) begin
                hold_addr <= sel_word;
            end
        end else if (rsp_done) begin
            rsp_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_arb2.sv
// Self-checking bench for sram_arb2: behavioural RAM, transaction-level reference model,
// directed corner sequences, an arbitration vector table and randomized traffic.
module tb_sram_arb2;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cmd_valid, m0_cmd_read, m0_rsp_ready;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m1_cmd_valid, m1_cmd_read, m1_rsp_ready;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata;
    logic [3:0]  m1_cmd_wmask;
    logic        m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we;
    logic [3:0]  ram_wem;

    logic        f_m0_cmd_ready, f_m1_cmd_ready, f_m0_rsp_valid, f_m1_rsp_valid;
    logic [31:0] f_m0_rsp_rdata, f_m1_rsp_rdata, f_ram_addr, f_ram_din;
    logic        f_ram_we;
    logic [3:0]  f_ram_wem;
    logic [31:0] f_ram_dout = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arb2 #(.AW(32), .DW(32), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wem(ram_wem), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    sram_arb2 #(.AW(32), .DW(32), .ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(f_m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(f_m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(f_m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(f_m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(f_m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(f_m1_rsp_rdata),
        .ram_addr(f_ram_addr), .ram_we(f_ram_we), .ram_wem(f_ram_wem), .ram_din(f_ram_din),
        .ram_dout(f_ram_dout)
    );

    // Behavioural single-port RAM with one cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= merge(mem[ram_addr[7:0]], ram_din, ram_wem);
        ram_dout <= mem[ram_addr[7:0]];
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction, its expected data, memory image, last winner.
    logic [31:0] mmem [256];
    bit          pend, owner, last;
    logic [31:0] pdata, hold;

    task automatic model_reset();
        pend = 0; owner = 0; last = 1; pdata = 0; hold = 0;
    endtask

    // Check one cycle against the model, advance the model, then move to the next negedge.
    task automatic step();
        bit          done, can, acc, win, rd;
        logic [31:0] w, wd;
        logic [3:0]  mk;
        #1;
        if (rst) begin
            chk("rst_rdy0", 32'(m0_cmd_ready), 0);
            chk("rst_rdy1", 32'(m1_cmd_ready), 0);
            chk("rst_rv0", 32'(m0_rsp_valid), 0);
            chk("rst_rv1", 32'(m1_rsp_valid), 0);
            chk("rst_we", 32'(ram_we), 0);
            chk("rst_wem", 32'(ram_wem), 0);
            model_reset();
        end else begin
            done = pend && (owner ? m1_rsp_ready : m0_rsp_ready);
            can  = !pend || done;
            acc  = can && (m0_cmd_valid || m1_cmd_valid);
            // A contest goes to the port that did not win the previous accepted command.
            win  = (m0_cmd_valid && m1_cmd_valid) ? !last : m1_cmd_valid;
            rd   = win ? m1_cmd_read : m0_cmd_read;
            w    = (win ? m1_cmd_addr : m0_cmd_addr) >> 2;
            wd   = win ? m1_cmd_wdata : m0_cmd_wdata;
            mk   = win ? m1_cmd_wmask : m0_cmd_wmask;
            chk("rdy0", 32'(m0_cmd_ready), 32'(acc && !win));
            chk("rdy1", 32'(m1_cmd_ready), 32'(acc && win));
            chk("rv0", 32'(m0_rsp_valid), 32'(pend && !owner));
            chk("rv1", 32'(m1_rsp_valid), 32'(pend && owner));
            chk("rdata0", m0_rsp_rdata, (pend && !owner) ? pdata : 32'h0);
            chk("rdata1", m1_rsp_rdata, (pend && owner) ? pdata : 32'h0);
            chk("ram_we", 32'(ram_we), 32'(acc && !rd));
            chk("ram_wem", 32'(ram_wem), (acc && !rd) ? 32'(mk) : 32'h0);
            chk("ram_addr", ram_addr, acc ? w : hold);
            if (acc && !rd) chk("ram_din", ram_din, wd);
            if (acc) begin
                pend = 1; owner = win; last = win;
                if (rd) begin
                    pdata = mmem[w[7:0]];
                    hold  = w;
                end else begin
                    pdata = 0;
                    mmem[w[7:0]] = merge(mmem[w[7:0]], wd, mk);
                end
            end else if (done) begin
                pend = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0;
        m0_cmd_valid = 0; m0_cmd_read = 1; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_wmask = 0;
        m1_cmd_valid = 0; m1_cmd_read = 1; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_wmask = 0;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
    endtask

    task automatic cmd(input bit port, input bit read, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
        if (port) begin
            m1_cmd_valid = 1; m1_cmd_read = read; m1_cmd_addr = addr;
            m1_cmd_wdata = wdata; m1_cmd_wmask = mask;
        end else begin
            m0_cmd_valid = 1; m0_cmd_read = read; m0_cmd_addr = addr;
            m0_cmd_wdata = wdata; m0_cmd_wmask = mask;
        end
    endtask

    typedef struct {
        logic v0, v1, rr0, rr1;
        logic e0, e1, f0, f1;
    } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 1, 1, 1, 1, 0, 1, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 1, 1, 0};
        tbl[2] = '{1, 1, 1, 1, 1, 0, 1, 0};
        tbl[3] = '{1, 1, 1, 1, 0, 1, 1, 0};
        tbl[4] = '{1, 0, 1, 1, 1, 0, 1, 0};
        tbl[5] = '{0, 1, 1, 1, 0, 1, 0, 1};
        tbl[6] = '{1, 1, 0, 1, 1, 0, 1, 0};
        tbl[7] = '{1, 1, 0, 1, 0, 0, 0, 0};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 0;
            mmem[i] = 0;
        end
        model_reset();
        idle();
        rst = 1;
        @(negedge clk);
        step();
        step();

        // Write then read back through the other port.
        idle(); cmd(1, 0, 32'h8, 32'hDEADBEEF, 4'hF); step();
        idle(); cmd(0, 1, 32'h8, 0, 0);
        #1 chk("t1_wr_rsp_valid", 32'(m1_rsp_valid), 1);
        chk("t1_wr_rsp_rdata", m1_rsp_rdata, 0);
        step();
        idle();
        #1 chk("t1_rd_data", m0_rsp_rdata, 32'hDEADBEEF);
        step();

        // Partial byte write followed immediately by a read of the same word.
        idle(); cmd(1, 0, 32'h8, 32'h11223344, 4'b0101); step();
        idle(); cmd(1, 1, 32'hB, 0, 0); step();
        idle();
        #1 chk("t2_masked_data", m1_rsp_rdata, 32'hDE22BE44);
        step();

        // Stalled response blocks both command ports and holds the RAM address.
        idle(); cmd(1, 0, 32'h10, 32'hA5A5A5A5, 4'hF); step();
        idle(); cmd(0, 1, 32'h10, 0, 0); step();
        idle(); m0_rsp_ready = 0; cmd(1, 1, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_rdy1_stall", 32'(m1_cmd_ready), 0);
            chk("t4_rdy0_stall", 32'(m0_cmd_ready), 0);
            chk("t4_we_stall", 32'(ram_we), 0);
            chk("t4_addr_hold", ram_addr, 32'h4);
            chk("t4_data_hold", m0_rsp_rdata, 32'hA5A5A5A5);
            step();
        end
        m0_rsp_ready = 1;
        #1 chk("t4_release", 32'(m1_cmd_ready), 1);
        step();
        idle(); step();

        // Back-to-back write stream, then a streamed read-back on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            idle(); cmd(1, 0, 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF); step();
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) cmd(1, 1, 32'(4 * i), 0, 0);
            if (i > 0) begin
                #1 chk("t5_stream_valid", 32'(m1_rsp_valid), 1);
                chk("t5_stream_data", m1_rsp_rdata, 32'h1000_0000 + 32'(i - 1));
            end
            step();
        end

        // Arbitration table, round-robin and fixed-priority instances side by side.
        idle(); rst = 1; step();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (tbl[i].v0) cmd(0, 1, 32'h0, 0, 0);
            if (tbl[i].v1) cmd(1, 1, 32'h4, 0, 0);
            m0_rsp_ready = tbl[i].rr0;
            m1_rsp_ready = tbl[i].rr1;
            #1 chk($sformatf("tbl%0d_rr_rdy0", i), 32'(m0_cmd_ready), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d_rr_rdy1", i), 32'(m1_cmd_ready), 32'(tbl[i].e1));
            chk($sformatf("tbl%0d_fix_rdy0", i), 32'(f_m0_cmd_ready), 32'(tbl[i].f0));
            chk($sformatf("tbl%0d_fix_rdy1", i), 32'(f_m1_cmd_ready), 32'(tbl[i].f1));
            step();
        end
        idle(); step();

        // Reset with a response pending and a write presented: write dropped, m0 wins afterwards.
        idle(); cmd(1, 1, 32'h0, 0, 0); step();
        idle(); rst = 1; m1_rsp_ready = 0; cmd(0, 0, 32'h0, 32'hFFFFFFFF, 4'hF); step();
        idle();
        #1 chk("t6_rsp_dropped", 32'(m1_rsp_valid), 0);
        step();
        idle(); cmd(0, 1, 32'h0, 0, 0); cmd(1, 1, 32'h4, 0, 0);
        #1 chk("t6_first_m0", 32'(m0_cmd_ready), 1);
        step();
        idle();
        #1 chk("t6_mem_intact", m0_rsp_rdata, 32'h1000_0000);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            m0_cmd_valid = $urandom_range(0, 1) == 1;
            m0_cmd_read  = $urandom_range(0, 1) == 1;
            m0_cmd_addr  = 32'($urandom_range(0, 63));
            m0_cmd_wdata = $urandom;
            m0_cmd_wmask = 4'($urandom_range(0, 15));
            m1_cmd_valid = $urandom_range(0, 1) == 1;
            m1_cmd_read  = $urandom_range(0, 1) == 1;
            m1_cmd_addr  = 32'($urandom_range(0, 63));
            m1_cmd_wdata = $urandom;
            m1_cmd_wmask = 4'($urandom_range(0, 15));
            m0_rsp_ready = $urandom_range(0, 3) != 0;
            m1_rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
